// File: rtl/fetch_sequencer.sv
// Fetch/issue controller for the 3-bit program counter. It walks the counter,
// reads an 8-entry instruction store and issues decoded fields over valid/ready.
module fetch_sequencer #(
    parameter int         INSTR_W = 12,
    parameter bit         WRAP_EN = 1'b0,
    parameter logic [2:0] HALT_OP = 3'b111
) (
    input  logic               CLK,
    input  logic               clear_n,
    input  logic               start,
    input  logic               prog_we,
    input  logic [2:0]         prog_addr,
    input  logic [INSTR_W-1:0] prog_data,
    input  logic [2:0]         pc_in,
    output logic               pc_clear,
    output logic               pc_enable,
    output logic               pc_increment,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [2:0]         op,
    output logic [2:0]         rd,
    output logic [2:0]         ra,
    output logic [2:0]         rb_imm,
    output logic [2:0]         instr_addr,
    output logic               busy,
    output logic               halted,
    output logic [2:0]         dbg_state
);

    // Handshake: an instruction transfers on any rising CLK edge where
    // instr_valid && instr_ready; valid and fields stay fixed until then.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_ADV    = 3'd2,
        S_READ   = 3'd3,
        S_ISSUE  = 3'd4,
        S_HALTED = 3'd5
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [INSTR_W-1:0] mem [8];
    logic [INSTR_W-1:0] ir;

    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge CLK or negedge clear_n) begin
        if (!clear_n) begin
            ir         <= '0;
            instr_addr <= 3'd0;
        end else if (state == S_READ) begin
            ir         <= mem[pc_in];
            instr_addr <= pc_in;
        end
    end

    // The store keeps its contents through reset.
    always_ff @(posedge CLK) begin
        if (state == S_IDLE && prog_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_clear     = 1'b0;
        pc_enable    = 1'b0;
        pc_increment = 1'b0;
        instr_valid  = 1'b0;
        busy         = 1'b1;
        halted       = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_CLR;
            end
            S_CLR: begin
                pc_clear  = 1'b1;
                state_nxt = S_ADV;
            end
            S_ADV: begin
                pc_enable    = 1'b1;
                pc_increment = 1'b1;
                state_nxt    = S_READ;
            end
            S_READ: begin
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    if (op == HALT_OP) begin
                        state_nxt = S_HALTED;
                    end else if (instr_addr == 3'd7 && !WRAP_EN) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_ADV;
                    end
                end
            end
            S_HALTED: begin
                busy   = 1'b0;
                halted = 1'b1;
                if (start) state_nxt = S_CLR;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign op        = ir[11:9];
    assign rd        = ir[8:6];
    assign ra        = ir[5:3];
    assign rb_imm    = ir[2:0];
    assign dbg_state = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: table-driven program loads, a scoreboard
// of expected issues, and hand-written sequences for timing and corner cases.
module tb_fetch_sequencer;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd4;
    localparam logic [2:0] ST_HALTED = 3'd5;

    typedef struct packed {
        logic [2:0]  addr;
        logic [11:0] data;
    } vec_t;

    logic        CLK;
    logic        clear_n;
    logic        start;
    logic        start_w;
    logic        prog_we;
    logic [2:0]  prog_addr;
    logic [11:0] prog_data;
    logic        instr_ready;

    logic [2:0]  pc;
    logic        pc_clear, pc_enable, pc_increment, instr_valid, busy, halted;
    logic [2:0]  op, rd, ra, rb_imm, instr_addr, dbg_state;

    logic [2:0]  pc_w;
    logic        pc_clear_w, pc_enable_w, pc_increment_w, instr_valid_w, busy_w, halted_w;
    logic [2:0]  op_w, rd_w, ra_w, rb_imm_w, instr_addr_w, dbg_state_w;

    logic [20:0] outs, outs_w;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [14:0] exp_q[$];
    vec_t        prog_a[4];
    vec_t        prog_b[8];
    bit          ok;

    fetch_sequencer #(.INSTR_W(12), .WRAP_EN(1'b0), .HALT_OP(3'b111)) dut (
        .CLK(CLK), .clear_n(clear_n), .start(start), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .pc_in(pc),
        .pc_clear(pc_clear), .pc_enable(pc_enable), .pc_increment(pc_increment),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .op(op), .rd(rd), .ra(ra), .rb_imm(rb_imm), .instr_addr(instr_addr),
        .busy(busy), .halted(halted), .dbg_state(dbg_state)
    );

    fetch_sequencer #(.INSTR_W(12), .WRAP_EN(1'b1), .HALT_OP(3'b111)) dut_w (
        .CLK(CLK), .clear_n(clear_n), .start(start_w), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data), .pc_in(pc_w),
        .pc_clear(pc_clear_w), .pc_enable(pc_enable_w), .pc_increment(pc_increment_w),
        .instr_valid(instr_valid_w), .instr_ready(instr_ready),
        .op(op_w), .rd(rd_w), .ra(ra_w), .rb_imm(rb_imm_w), .instr_addr(instr_addr_w),
        .busy(busy_w), .halted(halted_w), .dbg_state(dbg_state_w)
    );

    assign outs   = {pc_clear, pc_enable, pc_increment, instr_valid, busy, halted,
                     op, rd, ra, rb_imm, instr_addr};
    assign outs_w = {pc_clear_w, pc_enable_w, pc_increment_w, instr_valid_w, busy_w, halted_w,
                     op_w, rd_w, ra_w, rb_imm_w, instr_addr_w};

    // Clock and the external program counters (not reset by the sequencer).
    initial begin
        CLK  = 1'b0;
        pc   = 3'd5;
        pc_w = 3'd2;
    end
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (pc_clear) pc <= 3'b111;
        else if (pc_enable && pc_increment) pc <= pc + 3'd1;
        if (pc_clear_w) pc_w <= 3'b111;
        else if (pc_enable_w && pc_increment_w) pc_w <= pc_w + 3'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic load(input logic [2:0] a, input logic [11:0] d);
        prog_addr = a;
        prog_data = d;
        prog_we   = 1'b1;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic wait_valid(input int max_cycles, input string name, output bit found);
        found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            tick();
            if (instr_valid) found = 1'b1;
        end
        if (!found) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_halted(input int max_cycles, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < max_cycles && !found; i++) begin
            tick();
            if (halted) found = 1'b1;
        end
        check({name, "_halted"}, {31'd0, found}, 32'd1);
    endtask

    // Scoreboard: every accepted issue on dut must match the next expected entry.
    always @(negedge CLK) begin
        if (clear_n && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_issue", {29'd0, instr_addr}, 32'hffff_ffff);
            end else begin
                check("issue", {17'd0, instr_addr, op, rd, ra, rb_imm}, {17'd0, exp_q.pop_front()});
            end
        end
        if (clear_n && pc_clear && (pc_enable || pc_increment)) begin
            check("pc_overlap", 32'd1, 32'd0);
        end
    end

    initial begin
        prog_a[0] = '{addr: 3'd0, data: 12'h041};
        prog_a[1] = '{addr: 3'd1, data: 12'h0CA};
        prog_a[2] = '{addr: 3'd2, data: 12'h113};
        prog_a[3] = '{addr: 3'd3, data: 12'hE00};
        prog_b[0] = '{addr: 3'd0, data: 12'h041};
        prog_b[1] = '{addr: 3'd1, data: 12'h0CA};
        prog_b[2] = '{addr: 3'd2, data: 12'h113};
        prog_b[3] = '{addr: 3'd3, data: 12'h2D5};
        prog_b[4] = '{addr: 3'd4, data: 12'h45E};
        prog_b[5] = '{addr: 3'd5, data: 12'h6A7};
        prog_b[6] = '{addr: 3'd6, data: 12'hC38};
        prog_b[7] = '{addr: 3'd7, data: 12'hA01};

        clear_n = 1'b0; start = 1'b0; start_w = 1'b0; prog_we = 1'b0;
        prog_addr = 3'd0; prog_data = 12'h000; instr_ready = 1'b0;

        // Reset state
        #3;
        check("reset_outs", {11'd0, outs}, 32'd0);
        check("reset_outs_w", {11'd0, outs_w}, 32'd0);
        check("reset_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        tick();
        clear_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_outs", {11'd0, outs}, 32'd0);
        end

        // Run 1: four-instruction program ending in halt
        foreach (prog_a[i]) load(prog_a[i].addr, prog_a[i].data);
        foreach (prog_a[i]) exp_q.push_back({prog_a[i].addr, prog_a[i].data});
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("clr_cycle", {29'd0, pc_clear, pc_enable, pc_increment}, 32'b100);
        tick();
        check("adv_cycle", {29'd0, pc_clear, pc_enable, pc_increment}, 32'b011);
        tick();
        check("read_cycle", {28'd0, pc_clear, pc_enable, pc_increment, instr_valid}, 32'd0);
        tick();
        check("first_valid", {31'd0, instr_valid}, 32'd1);
        check("first_fields", {20'd0, op, rd, ra, rb_imm}, {20'd0, 3'd0, 3'd1, 3'd0, 3'd1});
        check("first_addr", {29'd0, instr_addr}, 32'd0);
        for (int k = 1; k < 4; k++) begin
            repeat (3) tick();
            check("spaced_valid", {31'd0, instr_valid}, 32'd1);
            check("spaced_addr", {29'd0, instr_addr}, k);
        end
        tick();
        check("halt_flags", {29'd0, halted, busy, instr_valid}, 32'b100);
        check("halt_state", {29'd0, dbg_state}, {29'd0, ST_HALTED});

        // Run 2: backpressure at address 1, ignored write and start while busy
        foreach (prog_a[i]) exp_q.push_back({prog_a[i].addr, prog_a[i].data});
        start = 1'b1;
        tick();
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (instr_valid && instr_addr == 3'd1) ok = 1'b1;
        end
        check("reach_addr1", {31'd0, ok}, 32'd1);
        instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                prog_addr = 3'd2; prog_data = 12'hFFF; prog_we = 1'b1;
            end else begin
                prog_we = 1'b0;
            end
            start = (i == 3);
            tick();
            check("bp_valid", {31'd0, instr_valid}, 32'd1);
            check("bp_fields", {20'd0, op, rd, ra, rb_imm}, {20'd0, 12'h0CA});
            check("bp_pc_ctl", {29'd0, pc_clear, pc_enable, pc_increment}, 32'd0);
        end
        prog_we = 1'b0;
        start = 1'b0;
        instr_ready = 1'b1;
        tick();
        check("bp_release", {30'd0, instr_valid, pc_enable}, 32'b01);
        wait_halted(20, "run2");

        // Run 3: reset while an instruction is waiting in ISSUE
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(10, "run3", ok);
        check("run3_state", {29'd0, dbg_state}, {29'd0, ST_ISSUE});
        clear_n = 1'b0;
        #1;
        check("async_drop", {31'd0, instr_valid}, 32'd0);
        check("async_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        tick();
        clear_n = 1'b1;

        // Run 4: no halt in store, last write coincides with start
        for (int i = 0; i < 7; i++) load(prog_b[i].addr, prog_b[i].data);
        foreach (prog_b[i]) exp_q.push_back({prog_b[i].addr, prog_b[i].data});
        instr_ready = 1'b1;
        prog_addr = prog_b[7].addr; prog_data = prog_b[7].data; prog_we = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0; prog_we = 1'b0;
        check("run4_clr", {31'd0, pc_clear}, 32'd1);
        repeat (3) tick();
        check("run4_addr0", {28'd0, instr_valid, instr_addr}, 32'b1000);
        for (int k = 1; k < 8; k++) begin
            repeat (3) tick();
            check("run4_addr", {28'd0, instr_valid, instr_addr}, {28'd0, 1'b1, 3'(k)});
        end
        tick();
        check("nowrap_idle", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("nowrap_flags", {29'd0, busy, halted, instr_valid}, 32'd0);
        repeat (3) tick();
        check("nowrap_stays", {30'd0, instr_valid, busy}, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);

        // Wrapping instance: address 7 is followed by address 0
        start_w = 1'b1;
        tick();
        start_w = 1'b0;
        repeat (3) tick();
        check("wrap_addr0", {28'd0, instr_valid_w, instr_addr_w}, 32'b1000);
        for (int k = 1; k < 9; k++) begin
            repeat (3) tick();
            check("wrap_addr", {27'd0, busy_w, instr_valid_w, instr_addr_w},
                  {27'd0, 2'b11, 3'(k % 8)});
        end
        check("wrap_fields", {20'd0, op_w, rd_w, ra_w, rb_imm_w}, {20'd0, 12'h041});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
